arc4_ctrl: RTL

ARC4_CTRL -- requirements
Module: arc4_ctrl

---
 rtl/arc4_pkg.sv | 49 ++++
 rtl/arc4_ctrl_s_mem_mux.sv | 58 +++++
 rtl/arc4_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arc4_pkg
//  Description : Shared definitions for the ARC4 controller slice. It holds
//                the controller state encoding, the phase codes reported on
//                the phase output, and the requester indices. The requester
//                indices also give the bit order of sub_en/sub_rdy/req_wren
//                and the slice order of req_addr/req_wrdata.
//  Revision    : 1.0  initial release
// ============================================================================
package arc4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START_INIT = 3'd1,
      ST_WAIT_INIT  = 3'd2,
      ST_START_KSA  = 3'd3,
      ST_WAIT_KSA   = 3'd4,
      ST_START_PRGA = 3'd5,
      ST_WAIT_PRGA  = 3'd6
   } state_t;

   localparam logic [1:0] PH_IDLE = 2'd0;
   localparam logic [1:0] PH_INIT = 2'd1;
   localparam logic [1:0] PH_KSA  = 2'd2;
   localparam logic [1:0] PH_PRGA = 2'd3;

   localparam int REQ_INIT = 0;
   localparam int REQ_KSA  = 1;
   localparam int REQ_PRGA = 2;
   localparam int NUM_REQ  = 3;

   // Phase reported for a state. The START and WAIT states of a sub-block
   // share that sub-block's phase.
   function automatic logic [1:0] phase_of(input state_t s);
      case (s)
         ST_START_INIT, ST_WAIT_INIT: phase_of = PH_INIT;
         ST_START_KSA,  ST_WAIT_KSA:  phase_of = PH_KSA;
         ST_START_PRGA, ST_WAIT_PRGA: phase_of = PH_PRGA;
         default:                     phase_of = PH_IDLE;
      endcase
   endfunction

   function automatic logic is_wait(input state_t s);
      is_wait = (s == ST_WAIT_INIT) || (s == ST_WAIT_KSA) || (s == ST_WAIT_PRGA);
   endfunction

endpackage
`default_nettype wire

// File: rtl/arc4_ctrl_s_mem_mux.sv
`default_nettype none
// ============================================================================
//  Module      : s_mem_mux
//  Description : Routes one of three requesters onto the single S-memory
//                port. Purely combinational.
//  Ports       : sel        - phase code (0 idle, 1 init, 2 ksa, 3 prga)
//                req_addr   - 3 packed addresses, slice i = [i*ADDR_W +: ADDR_W]
//                req_wrdata - 3 packed write data words, same slicing
//                req_wren   - per-requester write enables
//                s_addr, s_wrdata, s_wren - S-memory port
//  Revision    : 1.0  initial release
// ============================================================================
module s_mem_mux #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic [1:0]          sel,
   input  logic [3*ADDR_W-1:0] req_addr,
   input  logic [3*DATA_W-1:0] req_wrdata,
   input  logic [2:0]          req_wren,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wrdata,
   output logic                s_wren
);
   import arc4_pkg::*;

   // Only the selected requester's write enable is looked at, so an idle
   // sub-block can never write the shared memory. In idle everything is 0.
   always_comb begin
      s_addr   = '0;
      s_wrdata = '0;
      s_wren   = 1'b0;
      case (sel)
         PH_INIT: begin
            s_addr   = req_addr[REQ_INIT*ADDR_W +: ADDR_W];
            s_wrdata = req_wrdata[REQ_INIT*DATA_W +: DATA_W];
            s_wren   = req_wren[REQ_INIT];
         end
         PH_KSA: begin
            s_addr   = req_addr[REQ_KSA*ADDR_W +: ADDR_W];
            s_wrdata = req_wrdata[REQ_KSA*DATA_W +: DATA_W];
            s_wren   = req_wren[REQ_KSA];
         end
         PH_PRGA: begin
            s_addr   = req_addr[REQ_PRGA*ADDR_W +: ADDR_W];
            s_wrdata = req_wrdata[REQ_PRGA*DATA_W +: DATA_W];
            s_wren   = req_wren[REQ_PRGA];
         end
         default: begin
            s_addr   = '0;
            s_wrdata = '0;
            s_wren   = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/arc4_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arc4_ctrl
//  Description : Sequences the ARC4 sub-blocks init -> ksa -> prga and
//                grants the shared single-port S memory to the active one.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                en / rdy    - start request / controller idle
//                done        - one-cycle pulse when prga finishes
//                phase       - 0 idle, 1 init, 2 ksa, 3 prga
//                sub_en      - registered start pulses (bit0 init, 1 ksa, 2 prga)
//                sub_rdy     - sub-block ready, same bit order
//                req_*       - per-requester S-memory requests
//                s_*         - S-memory port
//  Revision    : 1.0  initial release
// ============================================================================
module arc4_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   output logic                rdy,
   output logic                done,
   output logic [1:0]          phase,
   output logic [2:0]          sub_en,
   input  logic [2:0]          sub_rdy,
   input  logic [3*ADDR_W-1:0] req_addr,
   input  logic [3*DATA_W-1:0] req_wrdata,
   input  logic [2:0]          req_wren,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wrdata,
   output logic                s_wren
);
   import arc4_pkg::*;

   state_t     state;
   state_t     next_state;
   logic       wait_first;
   logic       wait_first_d;
   logic [2:0] sub_en_d;
   logic       done_d;

   // State register plus the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         sub_en     <= 3'b000;
         done       <= 1'b0;
         wait_first <= 1'b0;
      end else begin
         state      <= next_state;
         sub_en     <= sub_en_d;
         done       <= done_d;
         wait_first <= wait_first_d;
      end
   end

   // Next-state logic. A START state leaves once its pulse has been on
   // sub_en for a cycle; a WAIT state ignores sub_rdy in its first cycle
   // because a sub-block may not have dropped ready yet.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:       if (en)                                  next_state = ST_START_INIT;
         ST_START_INIT: if (sub_en[REQ_INIT])                    next_state = ST_WAIT_INIT;
         ST_WAIT_INIT:  if (!wait_first && sub_rdy[REQ_INIT])    next_state = ST_START_KSA;
         ST_START_KSA:  if (sub_en[REQ_KSA])                     next_state = ST_WAIT_KSA;
         ST_WAIT_KSA:   if (!wait_first && sub_rdy[REQ_KSA])     next_state = ST_START_PRGA;
         ST_START_PRGA: if (sub_en[REQ_PRGA])                    next_state = ST_WAIT_PRGA;
         ST_WAIT_PRGA:  if (!wait_first && sub_rdy[REQ_PRGA])    next_state = ST_IDLE;
         default:                                                next_state = ST_IDLE;
      endcase
   end

   // Outputs. sub_en is issued from the register so the pulse lands in the
   // first START cycle in which the sub-block was seen ready; the START
   // state then leaves, which limits the pulse to exactly one cycle.
   always_comb begin
      rdy          = (state == ST_IDLE);
      phase        = phase_of(state);
      sub_en_d     = 3'b000;
      sub_en_d[REQ_INIT] = (next_state == ST_START_INIT) && sub_rdy[REQ_INIT];
      sub_en_d[REQ_KSA]  = (next_state == ST_START_KSA)  && sub_rdy[REQ_KSA];
      sub_en_d[REQ_PRGA] = (next_state == ST_START_PRGA) && sub_rdy[REQ_PRGA];
      done_d       = (state == ST_WAIT_PRGA) && (next_state == ST_IDLE);
      wait_first_d = is_wait(next_state) && (next_state != state);
   end

   s_mem_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_s_mem_mux (
      .sel        (phase),
      .req_addr   (req_addr),
      .req_wrdata (req_wrdata),
      .req_wren   (req_wren),
      .s_addr     (s_addr),
      .s_wrdata   (s_wrdata),
      .s_wren     (s_wren)
   );

endmodule
`default_nettype wire
